bcd_seg_driver: RTL and testbench

- Display back-end that consumes the binary sequence value produced by the sequence/counter FSM and drives the two 7-segment digits seg1 (tens) and seg0 (units).
- Converts binary to two BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock, then decodes each digit to active-low segments.
- Has a one-deep pending buffer, so a value presented while a conversion is running is not lost.

---
 rtl/bcd_seg_driver.sv | 120 ++++++++++++
 tb/tb_bcd_seg_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_driver.sv
// rtl/bcd_seg_driver.sv - binary to two-digit BCD (shift-add-3) with active-low 7-segment outputs
// One input bit per clock; a one-deep pending slot keeps the latest value offered while busy.
module bcd_seg_driver #(
  parameter int n        = 4,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_done,
  output logic [3:0]   tens,
  output logic [3:0]   units,
  output logic [6:0]   seg1,
  output logic [6:0]   seg0
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [2:0] N_CNT = 3'(n);

  logic [1:0]   state;
  logic [n-1:0] sr;
  logic [7:0]   bcd;
  logic [2:0]   cnt;
  logic [n-1:0] pend_data;
  logic         pend;
  logic [3:0]   lo_adj;
  logic [3:0]   hi_adj;
  logic [n+7:0] cat;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Tens nibble never exceeds 6 for n<=6, so no carry out of it is kept.
  always_comb begin
    lo_adj = bcd[3:0];
    hi_adj = bcd[7:4];
    if (lo_adj >= 4'd5) lo_adj = lo_adj + 4'd3;
    if (hi_adj >= 4'd5) hi_adj = hi_adj + 4'd3;
    cat = {hi_adj, lo_adj, sr} << 1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      sr        <= '0;
      bcd       <= '0;
      cnt       <= '0;
      pend_data <= '0;
      pend      <= 1'b0;
      out_done  <= 1'b0;
      tens      <= '0;
      units     <= '0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= in_data;
            bcd   <= '0;
            cnt   <= N_CNT;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= cat[n+7:n];
          sr  <= cat[n-1:0];
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= DONE;
          if (in_valid) begin
            pend_data <= in_data;
            pend      <= 1'b1;
          end
        end
        DONE: begin
          tens     <= bcd[7:4];
          units    <= bcd[3:0];
          out_done <= 1'b1;
          // A fresh input outranks the buffered one; the buffer is kept for later.
          if (in_valid) begin
            sr    <= in_data;
            bcd   <= '0;
            cnt   <= N_CNT;
            state <= SHIFT;
          end else if (pend) begin
            sr    <= pend_data;
            bcd   <= '0;
            cnt   <= N_CNT;
            pend  <= 1'b0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign seg0     = seg_decode(units);
  assign seg1     = (BLANK_LZ && tens == 4'd0) ? 7'b1111111 : seg_decode(tens);

endmodule

// File: tb/tb_bcd_seg_driver.sv
// tb/tb_bcd_seg_driver.sv - directed self-checking bench for bcd_seg_driver
// Three instances: n=4, n=4 with leading-zero blanking, and n=6.
module tb_bcd_seg_driver;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [3:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_done;
  logic [3:0] a_tens, a_units;
  logic [6:0] a_seg1, a_seg0;

  logic [3:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_done;
  logic [3:0] b_tens, b_units;
  logic [6:0] b_seg1, b_seg0;

  logic [5:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_done;
  logic [3:0] c_tens, c_units;
  logic [6:0] c_seg1, c_seg0;

  always #5 clk = ~clk;

  bcd_seg_driver #(.n(4), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .nreset(nreset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_done(a_done), .tens(a_tens), .units(a_units), .seg1(a_seg1), .seg0(a_seg0));

  bcd_seg_driver #(.n(4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .nreset(nreset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_done(b_done), .tens(b_tens), .units(b_units), .seg1(b_seg1), .seg0(b_seg0));

  bcd_seg_driver #(.n(6), .BLANK_LZ(1'b0)) dut_c (
    .clk(clk), .nreset(nreset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_done(c_done), .tens(c_tens), .units(c_units), .seg1(c_seg1), .seg0(c_seg0));

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ((a_done | b_done | c_done) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_done cycle %0d: got a=%b b=%b c=%b, want 0", i, a_done, b_done, c_done);
      end
    end
    n_checks++;
    if (a_seg1 !== 7'b1000000 || a_seg0 !== 7'b1000000 || a_tens !== 4'd0 || a_units !== 4'd0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: got seg1=%b seg0=%b tens=%0d units=%0d ready=%b, want 1000000 1000000 0 0 1",
               a_seg1, a_seg0, a_tens, a_units, a_ready);
    end
    n_checks++;
    if (b_seg1 !== 7'b1111111 || b_seg0 !== 7'b1000000 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_blank: got seg1=%b seg0=%b ready=%b, want 1111111 1000000 1", b_seg1, b_seg0, b_ready);
    end
    n_checks++;
    if (c_seg1 !== 7'b1000000 || c_seg0 !== 7'b1000000 || c_tens !== 4'd0 || c_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_n6: got seg1=%b seg0=%b tens=%0d ready=%b, want 1000000 1000000 0 1",
               c_seg1, c_seg0, c_tens, c_ready);
    end
  endtask

  task automatic test_convert_15();
    a_data = 4'd15; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (a_ready !== 1'b0 || a_done !== 1'b0) begin
        n_fail++;
        $display("FAIL busy15 after E%0d: got ready=%b done=%b, want 0 0", k, a_ready, a_done);
      end
      @(negedge clk);
    end
    n_checks++;
    if (a_done !== 1'b1 || a_tens !== 4'd1 || a_units !== 4'd5 || a_seg1 !== 7'b1111001 || a_seg0 !== 7'b0010010) begin
      n_fail++;
      $display("FAIL result15: got done=%b tens=%0d units=%0d seg1=%b seg0=%b, want 1 1 5 1111001 0010010",
               a_done, a_tens, a_units, a_seg1, a_seg0);
    end
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b0 || a_ready !== 1'b1 || a_tens !== 4'd1 || a_units !== 4'd5) begin
      n_fail++;
      $display("FAIL hold15: got done=%b ready=%b tens=%0d units=%0d, want 0 1 1 5", a_done, a_ready, a_tens, a_units);
    end
  endtask

  task automatic test_blank_lz();
    int lat;
    b_data = 4'd9; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    lat = 0;
    while (b_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 5 || b_seg1 !== 7'b1111111 || b_seg0 !== 7'b0010000) begin
      n_fail++;
      $display("FAIL blank9: got lat=%0d seg1=%b seg0=%b, want 5 1111111 0010000", lat, b_seg1, b_seg0);
    end
    @(negedge clk);
    b_data = 4'd10; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    lat = 0;
    while (b_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 5 || b_tens !== 4'd1 || b_units !== 4'd0 || b_seg1 !== 7'b1111001 || b_seg0 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL blank10: got lat=%0d tens=%0d units=%0d seg1=%b seg0=%b, want 5 1 0 1111001 1000000",
               lat, b_tens, b_units, b_seg1, b_seg0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    a_data = 4'd10; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    a_data = 4'd4; a_valid = 1'b1;
    @(negedge clk);
    a_data = 4'd9;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early: got done=%b after E4, want 0", a_done);
    end
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b1 || a_tens !== 4'd1 || a_units !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b tens=%0d units=%0d, want 1 1 0", a_done, a_tens, a_units);
    end
    lat = 0;
    @(negedge clk); lat++;
    while (a_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 5 || a_tens !== 4'd0 || a_units !== 4'd9 || a_seg0 !== 7'b0010000) begin
      n_fail++;
      $display("FAIL b2b_second: got gap=%0d tens=%0d units=%0d seg0=%b, want 5 0 9 0010000",
               lat, a_tens, a_units, a_seg0);
    end
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (a_done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_extra: got done=%b with nothing queued, want 0", a_done);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    a_data = 4'd14; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 0;
    while (a_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 5 || a_tens !== 4'd1 || a_units !== 4'd4 || a_seg0 !== 7'b0011001) begin
      n_fail++;
      $display("FAIL conv14: got lat=%0d tens=%0d units=%0d seg0=%b, want 5 1 4 0011001", lat, a_tens, a_units, a_seg0);
    end
    @(negedge clk);
    a_data = 4'd3; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (a_tens !== 4'd0 || a_units !== 4'd0 || a_seg1 !== 7'b1000000 || a_seg0 !== 7'b1000000 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got tens=%0d units=%0d seg1=%b seg0=%b ready=%b done=%b, want 0 0 1000000 1000000 1 0",
               a_tens, a_units, a_seg1, a_seg0, a_ready, a_done);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_done cycle %0d: got done=%b, want 0", i, a_done);
      end
    end
    a_data = 4'd8; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 0;
    while (a_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 5 || a_tens !== 4'd0 || a_units !== 4'd8 || a_seg0 !== 7'b0000000 || a_seg1 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL conv8: got lat=%0d tens=%0d units=%0d seg0=%b seg1=%b, want 5 0 8 0000000 1000000",
               lat, a_tens, a_units, a_seg0, a_seg1);
    end
    @(negedge clk);
  endtask

  task automatic test_n6_max();
    int lat;
    c_data = 6'd63; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    lat = 0;
    while (c_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 7 || c_tens !== 4'd6 || c_units !== 4'd3 || c_seg1 !== 7'b0000010 || c_seg0 !== 7'b0110000) begin
      n_fail++;
      $display("FAIL n6_63: got lat=%0d tens=%0d units=%0d seg1=%b seg0=%b, want 7 6 3 0000010 0110000",
               lat, c_tens, c_units, c_seg1, c_seg0);
    end
    @(negedge clk);
    c_data = 6'd47; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    lat = 0;
    while (c_done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 7 || c_tens !== 4'd4 || c_units !== 4'd7 || c_seg1 !== 7'b0011001 || c_seg0 !== 7'b1111000) begin
      n_fail++;
      $display("FAIL n6_47: got lat=%0d tens=%0d units=%0d seg1=%b seg0=%b, want 7 4 7 0011001 1111000",
               lat, c_tens, c_units, c_seg1, c_seg0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_convert_15();
    test_blank_lz();
    test_back_to_back();
    test_reset_abort();
    test_n6_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
